// File: rtl/bcd_tens_tracker.sv
// -----------------------------------------------------------------------------
// bcd_tens_tracker
//
// Sits downstream of an up/down BCD ones-digit counter. Every clock it samples
// the counter digit {A,B,C,D} and the counter direction x, and extends the
// count with a tens digit by watching for 9->0 (up) and 0->9 (down) wraps.
// It drives registered 7-segment codes for both digits. A sticky error is
// raised on non-BCD codes, on jumps that are not a single step, and
// (optionally) on steps that disagree with the registered direction.
//
// Parameters
//   LEADING_BLANK : 1 = tens display blank (7'h00) while tens==0 in TRACK
//   CHECK_DIR     : 1 = a step against the registered direction is a fault
//
// Ports
//   clk            in   rising-edge clock shared with the ones counter
//   rst            in   asynchronous, active-low reset
//   A,B,C,D        in   ones digit from the counter, A is the MSB
//   x              in   counter direction, 0 = up, 1 = down
//   clr            in   synchronous clear back to INIT
//   tens[3:0]      out  tens digit 0..9
//   valid          out  1 while tracking
//   carry, borrow  out  one-cycle pulses on ones up/down wraps
//   ovf, unf       out  one-cycle pulses on tens up/down wraps
//   err            out  sticky fault flag
//   seg_ones[6:0]  out  {g,f,e,d,c,b,a} active-high code for the ones digit
//   seg_tens[6:0]  out  same encoding for the tens digit
// -----------------------------------------------------------------------------
module bcd_tens_tracker #(
    parameter bit LEADING_BLANK = 1'b1,
    parameter bit CHECK_DIR     = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       A,
    input  logic       B,
    input  logic       C,
    input  logic       D,
    input  logic       x,
    input  logic       clr,
    output logic [3:0] tens,
    output logic       valid,
    output logic       carry,
    output logic       borrow,
    output logic       ovf,
    output logic       unf,
    output logic       err,
    output logic [6:0] seg_ones,
    output logic [6:0] seg_tens
);

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_TRACK = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // 7-segment code of a BCD digit; non-BCD inputs never reach a display
    function automatic logic [6:0] seg_code(input logic [3:0] digit);
        case (digit)
            4'd0:    seg_code = 7'h3F;
            4'd1:    seg_code = 7'h06;
            4'd2:    seg_code = 7'h5B;
            4'd3:    seg_code = 7'h4F;
            4'd4:    seg_code = 7'h66;
            4'd5:    seg_code = 7'h6D;
            4'd6:    seg_code = 7'h7D;
            4'd7:    seg_code = 7'h07;
            4'd8:    seg_code = 7'h7F;
            4'd9:    seg_code = 7'h6F;
            default: seg_code = SEG_BLANK;
        endcase
    endfunction

    function automatic logic [6:0] tens_code(input logic [3:0] digit);
        if (LEADING_BLANK && digit == 4'd0)
            tens_code = SEG_BLANK;
        else
            tens_code = seg_code(digit);
    endfunction

    state_t     r_state;
    logic [3:0] r_tens;
    logic [3:0] r_prev;
    logic       r_x_q;
    logic       r_valid;
    logic       r_carry;
    logic       r_borrow;
    logic       r_ovf;
    logic       r_unf;
    logic       r_err;
    logic [6:0] r_seg_ones;
    logic [6:0] r_seg_tens;

    state_t     w_state_nxt;
    logic [3:0] w_tens_nxt;
    logic [3:0] w_prev_nxt;
    logic       w_valid_nxt;
    logic       w_carry_nxt;
    logic       w_borrow_nxt;
    logic       w_ovf_nxt;
    logic       w_unf_nxt;
    logic       w_err_nxt;
    logic [6:0] w_seg_ones_nxt;
    logic [6:0] w_seg_tens_nxt;

    logic [3:0] w_cur;
    logic       w_illegal;
    logic       w_up;
    logic       w_down;
    logic [3:0] w_tens_inc;
    logic [3:0] w_tens_dec;
    logic       w_go_fault;
    logic       w_commit;

    assign w_cur     = {A, B, C, D};
    assign w_illegal = (w_cur > 4'd9);
    // prev is always 0..9, so these cover single steps plus the decade wraps
    assign w_up      = (w_cur == r_prev + 4'd1) || (r_prev == 4'd9 && w_cur == 4'd0);
    assign w_down    = (r_prev != 4'd0 && w_cur == r_prev - 4'd1) ||
                       (r_prev == 4'd0 && w_cur == 4'd9);
    assign w_tens_inc = (r_tens == 4'd9) ? 4'd0 : r_tens + 4'd1;
    assign w_tens_dec = (r_tens == 4'd0) ? 4'd9 : r_tens - 4'd1;

    always_comb begin
        w_state_nxt    = r_state;
        w_tens_nxt     = r_tens;
        w_prev_nxt     = r_prev;
        w_valid_nxt    = r_valid;
        w_carry_nxt    = 1'b0;
        w_borrow_nxt   = 1'b0;
        w_ovf_nxt      = 1'b0;
        w_unf_nxt      = 1'b0;
        w_err_nxt      = r_err;
        w_seg_ones_nxt = r_seg_ones;
        w_seg_tens_nxt = r_seg_tens;
        w_go_fault     = 1'b0;
        w_commit       = 1'b0;

        if (clr) begin
            w_state_nxt    = S_INIT;
            w_tens_nxt     = 4'd0;
            w_err_nxt      = 1'b0;
            w_valid_nxt    = 1'b0;
            w_seg_ones_nxt = SEG_BLANK;
            w_seg_tens_nxt = SEG_BLANK;
        end else begin
            case (r_state)
                S_INIT: begin
                    if (w_illegal) begin
                        w_go_fault = 1'b1;
                    end else begin
                        w_state_nxt = S_TRACK;
                        w_valid_nxt = 1'b1;
                        w_commit    = 1'b1;
                    end
                end
                S_TRACK: begin
                    if (w_illegal) begin
                        w_go_fault = 1'b1;
                    end else if (w_cur == r_prev) begin
                        w_commit = 1'b1;
                    end else if (w_up) begin
                        // the step was taken under last cycle's direction
                        if (CHECK_DIR && r_x_q) begin
                            w_go_fault = 1'b1;
                        end else begin
                            w_commit = 1'b1;
                            if (r_prev == 4'd9) begin
                                w_carry_nxt = 1'b1;
                                w_ovf_nxt   = (r_tens == 4'd9);
                                w_tens_nxt  = w_tens_inc;
                            end
                        end
                    end else if (w_down) begin
                        if (CHECK_DIR && !r_x_q) begin
                            w_go_fault = 1'b1;
                        end else begin
                            w_commit = 1'b1;
                            if (r_prev == 4'd0) begin
                                w_borrow_nxt = 1'b1;
                                w_unf_nxt    = (r_tens == 4'd0);
                                w_tens_nxt   = w_tens_dec;
                            end
                        end
                    end else begin
                        w_go_fault = 1'b1;
                    end
                end
                S_FAULT: begin
                    // latched until clr or rst
                end
                default: begin
                    w_state_nxt = S_INIT;
                end
            endcase

            if (w_go_fault) begin
                w_state_nxt    = S_FAULT;
                w_err_nxt      = 1'b1;
                w_valid_nxt    = 1'b0;
                w_seg_ones_nxt = SEG_E;
                w_seg_tens_nxt = SEG_E;
            end else if (w_commit) begin
                // displays follow the new digit values on the same edge
                w_prev_nxt     = w_cur;
                w_seg_ones_nxt = seg_code(w_cur);
                w_seg_tens_nxt = tens_code(w_tens_nxt);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_INIT;
            r_tens     <= 4'd0;
            r_prev     <= 4'd0;
            r_x_q      <= 1'b0;
            r_valid    <= 1'b0;
            r_carry    <= 1'b0;
            r_borrow   <= 1'b0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
            r_err      <= 1'b0;
            r_seg_ones <= SEG_BLANK;
            r_seg_tens <= SEG_BLANK;
        end else begin
            r_state    <= w_state_nxt;
            r_tens     <= w_tens_nxt;
            r_prev     <= w_prev_nxt;
            r_x_q      <= x;
            r_valid    <= w_valid_nxt;
            r_carry    <= w_carry_nxt;
            r_borrow   <= w_borrow_nxt;
            r_ovf      <= w_ovf_nxt;
            r_unf      <= w_unf_nxt;
            r_err      <= w_err_nxt;
            r_seg_ones <= w_seg_ones_nxt;
            r_seg_tens <= w_seg_tens_nxt;
        end
    end

    assign tens     = r_tens;
    assign valid    = r_valid;
    assign carry    = r_carry;
    assign borrow   = r_borrow;
    assign ovf      = r_ovf;
    assign unf      = r_unf;
    assign err      = r_err;
    assign seg_ones = r_seg_ones;
    assign seg_tens = r_seg_tens;

endmodule

// File: tb/tb_bcd_tens_tracker.sv
// -----------------------------------------------------------------------------
// tb_bcd_tens_tracker
//
// Bench for bcd_tens_tracker. A behavioural model keeps the two-digit count as
// plain integers and classifies each sampled digit with modulo-10 arithmetic;
// each scenario task drives stimulus and compares the DUT outputs against it.
// -----------------------------------------------------------------------------
module tb_bcd_tens_tracker;

    localparam bit LB = 1'b1;
    localparam bit CD = 1'b1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] d   = 4'd0;
    logic       x   = 1'b0;
    logic       clr = 1'b0;

    logic [3:0] tens;
    logic       valid, carry, borrow, ovf, unf, err;
    logic [6:0] seg_ones, seg_tens;

    bcd_tens_tracker #(.LEADING_BLANK(LB), .CHECK_DIR(CD)) dut (
        .clk(clk), .rst(rst),
        .A(d[3]), .B(d[2]), .C(d[1]), .D(d[0]),
        .x(x), .clr(clr),
        .tens(tens), .valid(valid), .carry(carry), .borrow(borrow),
        .ovf(ovf), .unf(unf), .err(err),
        .seg_ones(seg_ones), .seg_tens(seg_tens)
    );

    always #5 clk = ~clk;

    int vecs  = 0;
    int fails = 0;

    // ---------------- reference model ----------------
    logic [6:0] SEG [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    int         m_mode;             // 0 waiting for first digit, 1 tracking, 2 faulted
    int         m_tens, m_prev;
    logic       m_xq, m_valid, m_carry, m_borrow, m_ovf, m_unf, m_err;
    logic [6:0] m_so, m_st;

    logic [23:0] obs_vec, exp_vec;
    logic [3:0]  m_tens4;
    assign m_tens4 = m_tens[3:0];
    assign obs_vec = {tens, valid, carry, borrow, ovf, unf, err, seg_ones, seg_tens};
    assign exp_vec = {m_tens4, m_valid, m_carry, m_borrow, m_ovf, m_unf, m_err, m_so, m_st};

    task automatic model_reset();
        m_mode = 0; m_tens = 0; m_prev = 0; m_xq = 1'b0;
        m_valid = 1'b0; m_carry = 1'b0; m_borrow = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        m_err = 1'b0; m_so = 7'h00; m_st = 7'h00;
    endtask

    // one rising edge: update the model from the inputs the DUT sampled,
    // then return 1 time unit after the edge
    task automatic tick();
        int c;
        bit bad;
        @(posedge clk);
        c = int'(d);
        bad = 1'b0;
        m_carry = 1'b0; m_borrow = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        if (clr) begin
            m_mode = 0; m_tens = 0; m_err = 1'b0; m_valid = 1'b0;
            m_so = 7'h00; m_st = 7'h00;
        end else if (m_mode != 2) begin
            if (c > 9) bad = 1'b1;
            else if (m_mode == 0) begin
                m_mode = 1; m_valid = 1'b1;
            end else if (c == m_prev) begin
            end else if (c == (m_prev + 1) % 10) begin
                if (CD && m_xq) bad = 1'b1;
                else if (m_prev == 9) begin
                    m_carry = 1'b1; m_ovf = (m_tens == 9); m_tens = (m_tens + 1) % 10;
                end
            end else if (c == (m_prev + 9) % 10) begin
                if (CD && !m_xq) bad = 1'b1;
                else if (m_prev == 0) begin
                    m_borrow = 1'b1; m_unf = (m_tens == 0); m_tens = (m_tens + 9) % 10;
                end
            end else bad = 1'b1;
            if (bad) begin
                m_mode = 2; m_err = 1'b1; m_valid = 1'b0; m_so = 7'h79; m_st = 7'h79;
            end else begin
                m_prev = c;
                m_so = SEG[c];
                m_st = (LB && m_tens == 0) ? 7'h00 : SEG[m_tens];
            end
        end
        m_xq = x;
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #1 rst = 1'b0;
        d = 4'd0; x = 1'b0; clr = 1'b0;
        model_reset();
        #5;
        vecs++;
        if (obs_vec !== 24'h0) begin
            fails++; $display("FAIL reset_hold: got %h expected %h", obs_vec, 24'h0);
        end
        #6 rst = 1'b1;
        tick();
        vecs++;
        if (obs_vec !== exp_vec) begin
            fails++; $display("FAIL first_edge: got %h expected %h", obs_vec, exp_vec);
        end
        vecs++;
        if ({valid, seg_ones, seg_tens, tens} !== {1'b1, 7'h3F, 7'h00, 4'd0}) begin
            fails++; $display("FAIL first_edge_abs: got %h expected %h",
                              {valid, seg_ones, seg_tens, tens}, {1'b1, 7'h3F, 7'h00, 4'd0});
        end
    endtask

    task automatic test_up_count();
        x = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            d = 4'(i % 10);
            tick();
            vecs++;
            if (obs_vec !== exp_vec) begin
                fails++; $display("FAIL up_count[%0d]: got %h expected %h", i, obs_vec, exp_vec);
            end
        end
        vecs++;
        if ({tens, carry, seg_tens} !== {4'd1, 1'b1, 7'h06}) begin
            fails++; $display("FAIL first_carry: got %h expected %h",
                              {tens, carry, seg_tens}, {4'd1, 1'b1, 7'h06});
        end
        d = 4'd1;
        tick();
        vecs++;
        if ({carry, obs_vec} !== {1'b0, exp_vec}) begin
            fails++; $display("FAIL carry_one_cycle: got %h expected %h", {carry, obs_vec}, {1'b0, exp_vec});
        end
    endtask

    task automatic test_ovf();
        // from 11 up to 100: 89 steps, the last one wraps tens 9->0
        for (int i = 0; i < 89; i++) begin
            d = (d == 4'd9) ? 4'd0 : d + 4'd1;
            tick();
            vecs++;
            if (obs_vec !== exp_vec) begin
                fails++; $display("FAIL ovf_run[%0d]: got %h expected %h", i, obs_vec, exp_vec);
            end
        end
        vecs++;
        if ({tens, carry, ovf, seg_tens} !== {4'd0, 1'b1, 1'b1, 7'h00}) begin
            fails++; $display("FAIL ovf_wrap: got %h expected %h",
                              {tens, carry, ovf, seg_tens}, {4'd0, 1'b1, 1'b1, 7'h00});
        end
    endtask

    task automatic test_down();
        for (int i = 1; i <= 10; i++) begin
            d = 4'(i % 10);
            tick();
            vecs++;
            if (obs_vec !== exp_vec) begin
                fails++; $display("FAIL down_setup[%0d]: got %h expected %h", i, obs_vec, exp_vec);
            end
        end
        x = 1'b1;
        tick();
        d = 4'd9;
        tick();
        vecs++;
        if ({tens, borrow, unf, obs_vec} !== {4'd0, 1'b1, 1'b0, exp_vec}) begin
            fails++; $display("FAIL first_borrow: got %h expected %h",
                              {tens, borrow, unf, obs_vec}, {4'd0, 1'b1, 1'b0, exp_vec});
        end
        for (int i = 8; i >= -1; i--) begin
            d = (i < 0) ? 4'd9 : 4'(i);
            tick();
            vecs++;
            if (obs_vec !== exp_vec) begin
                fails++; $display("FAIL down_run[%0d]: got %h expected %h", i, obs_vec, exp_vec);
            end
        end
        vecs++;
        if ({tens, borrow, unf, seg_tens} !== {4'd9, 1'b1, 1'b1, 7'h6F}) begin
            fails++; $display("FAIL unf_wrap: got %h expected %h",
                              {tens, borrow, unf, seg_tens}, {4'd9, 1'b1, 1'b1, 7'h6F});
        end
    endtask

    task automatic test_illegal_code();
        d = 4'b1100;
        tick();
        vecs++;
        if ({err, valid, seg_ones, seg_tens, obs_vec} !== {1'b1, 1'b0, 7'h79, 7'h79, exp_vec}) begin
            fails++; $display("FAIL illegal_code: got %h expected %h",
                              {err, valid, seg_ones, seg_tens}, {1'b1, 1'b0, 7'h79, 7'h79});
        end
        for (int i = 0; i < 4; i++) begin
            d = 4'(i);
            tick();
            vecs++;
            if ({err, obs_vec} !== {1'b1, exp_vec}) begin
                fails++; $display("FAIL fault_sticky[%0d]: got %h expected %h", i, obs_vec, exp_vec);
            end
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        vecs++;
        if ({err, tens, valid, seg_ones, seg_tens} !== {1'b0, 4'd0, 1'b0, 7'h00, 7'h00}) begin
            fails++; $display("FAIL clr_exit: got %h expected %h",
                              {err, tens, valid, seg_ones, seg_tens}, {1'b0, 4'd0, 1'b0, 7'h00, 7'h00});
        end
        d = 4'd2;
        tick();
        vecs++;
        if ({valid, seg_ones, obs_vec} !== {1'b1, 7'h5B, exp_vec}) begin
            fails++; $display("FAIL clr_reinit: got %h expected %h", {valid, seg_ones}, {1'b1, 7'h5B});
        end
    endtask

    task automatic test_jump_and_dir();
        x = 1'b0;
        tick();
        d = 4'd3;
        tick();
        d = 4'd5;
        tick();
        vecs++;
        if ({err, obs_vec} !== {1'b1, exp_vec}) begin
            fails++; $display("FAIL jump_3_5: got %h expected %h", obs_vec, exp_vec);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        d = 4'd3;
        tick();
        x = 1'b1;
        tick();
        d = 4'd4;
        tick();
        vecs++;
        if ({err, valid, obs_vec} !== {1'b1, 1'b0, exp_vec}) begin
            fails++; $display("FAIL dir_check: got %h expected %h", obs_vec, exp_vec);
        end
        x = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        vecs++;
        if ({err, valid, obs_vec} !== {1'b0, 1'b1, exp_vec}) begin
            fails++; $display("FAIL dir_recover: got %h expected %h", obs_vec, exp_vec);
        end
    endtask

    task automatic test_async_reset();
        d = 4'd5; tick();
        d = 4'd6; tick();
        #3 rst = 1'b0;
        model_reset();
        #1;
        vecs++;
        if (obs_vec !== 24'h0) begin
            fails++; $display("FAIL async_reset: got %h expected %h", obs_vec, 24'h0);
        end
        #1 rst = 1'b1;
        d = 4'd7;
        tick();
        vecs++;
        if ({valid, seg_ones, tens, obs_vec} !== {1'b1, 7'h07, 4'd0, exp_vec}) begin
            fails++; $display("FAIL post_reset: got %h expected %h", obs_vec, exp_vec);
        end
    endtask

    task automatic test_random();
        logic xdrv;
        int   r;
        xdrv = x;
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            clr = (r < 3);
            if (r >= 3 && r < 6) begin
                d = 4'($urandom_range(0, 15));
            end else if (r >= 6 && r < 30) begin
                if (d > 4'd9) d = 4'd0;
            end else if (r >= 30) begin
                if (d > 4'd9) d = 4'd0;
                // counter steps under the direction it saw last cycle
                else if (xdrv) d = (d == 4'd0) ? 4'd9 : d - 4'd1;
                else           d = (d == 4'd9) ? 4'd0 : d + 4'd1;
            end
            if ($urandom_range(0, 9) == 0) x = ~x;
            xdrv = x;
            tick();
            vecs++;
            if (obs_vec !== exp_vec) begin
                fails++; $display("FAIL random[%0d]: got %h expected %h", i, obs_vec, exp_vec);
            end
        end
        clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_up_count();
        test_ovf();
        test_down();
        test_illegal_code();
        test_jump_and_dir();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
